dma_rx_channel: RTL and testbench
=================================

Name: dma_rx_channel

Overview:
Single DMA channel that services an I/O device's transfer request (GPIO-style level request) and moves the device's buffered words into system memory. It takes the bus from the CPU, grants the device with an acknowledge, and drives the device's read strobe low. It then captures one databus word per clock and writes each word to consecutive memory addresses. A done pulse and a transferred-word count are reported back to the CPU.

Parameters:
DATA_W, 32, databus and memory word width
ADDR_W, 8, memory address width
MAX_LEN, 32, hard cap on words per transfer (device buffer depth)
CNT_W, 6, width of word counter (must hold MAX_LEN)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  channel armed; request is ignored when low
base_addr  input  ADDR_W  first memory address for the transfer, latched on request accept
dev_req  input  1  device transfer request (level, device GPIO line)
dev_ack  output  1  acknowledge to device (device's Ack input)
dev_iowrite  output  1  device read/write strobe; 0 = device drives databus
databus  input  DATA_W  word driven by device (device drives on falling edge)
bus_req  output  1  request system bus from CPU
bus_grant  input  1  CPU has released the bus
mem_we  output  1  memory write enable, one cycle per word
mem_addr  output  ADDR_W  memory write address
mem_wdata  output  DATA_W  memory write data
busy  output  1  high from request accept until DONE exits
done  output  1  one-cycle pulse at end of transfer
word_count  output  CNT_W  words written in last/current transfer

Behaviour:
- Reset values: dev_ack=0, dev_iowrite=1, bus_req=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, word_count=0; FSM=IDLE. Reset in any state aborts the transfer immediately with no further mem_we.
- States: IDLE, BUSREQ, ACK, XFER, DONE.
- IDLE: if enable && dev_req, latch base_addr into address pointer, clear word_count, go BUSREQ. busy=1 from the next cycle.
- BUSREQ: bus_req=1. Wait for bus_grant=1, then go ACK. If dev_req drops before the grant, go DONE with word_count=0.
- ACK: bus_req=1, dev_ack=1, dev_iowrite=0 for one cycle. The device places its first word on the following falling edge. Go XFER.
- XFER: bus_req, dev_ack=1, dev_iowrite=0 held.
  - Each rising edge samples databus and registers mem_we=1, mem_addr=pointer, mem_wdata=sample.
  - Pointer and word_count increment by 1.
  - Latency: sample-to-mem_we is 1 cycle; words are written back-to-back with no bubbles.
- XFER exit: after a sample, exit if dev_req==0 at that same edge or word_count reaches MAX_LEN. The device drops its request together with its last word, so that final word is still written.
- Address wrap: the pointer wraps modulo 2^ADDR_W with no error.
- DONE: dev_ack=0, dev_iowrite=1, bus_req=0, done=1 for exactly one cycle, then go IDLE. busy drops with the IDLE entry.
- enable deasserted mid-transfer has no effect until the transfer ends.
- dev_req still high in IDLE after DONE starts a new transfer. There is a minimum of 1 IDLE cycle between transfers.
- word_count holds its value in IDLE until the next accept.
- Only mem_we is pulsed; the other memory outputs hold their last value.

Test Plan:
- Basic 4-word transfer: base_addr=0x10; device raises req, holds 4 words 0x11..0x14, drops req with the 4th; bus_grant 2 cycles after bus_req -> mem writes 0x10..0x13 = 0x11..0x14 on consecutive cycles, one done pulse, word_count=4.
- Grant delay and early drop: bus_grant held low 10 cycles -> dev_ack stays 0 throughout. Separately, dev_req drops during BUSREQ -> no mem_we, done pulse, word_count=0.
- MAX_LEN cap: device keeps req high for 40 words -> exactly 32 writes, exit after the 32nd, word_count=32, dev_ack released.
- Wrap-around: base_addr=0xFE, 4 words -> writes at 0xFE, 0xFF, 0x00, 0x01.
- Reset in XFER: assert reset after the 2nd word -> all outputs at reset values the next cycle, no further mem_we, no done pulse.
- Gating and back-to-back: enable=0 with dev_req=1 -> stays IDLE, busy=0. Two transfers separated by DONE -> second starts after 1 IDLE cycle and word_count restarts from 0.

Source files
------------

// File: rtl/dma_rx_channel.sv
// dma_rx_channel: single DMA channel moving device-buffered words into memory.
// Takes the bus, acks the device, and writes one sampled word per clock.
module dma_rx_channel #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 8,
   parameter int MAX_LEN = 32,
   parameter int CNT_W   = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              dev_req,
   output logic              dev_ack,
   output logic              dev_iowrite,
   input  logic [DATA_W-1:0] databus,
   output logic              bus_req,
   input  logic              bus_grant,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  word_count
);
   typedef enum logic [2:0] {IDLE, BUSREQ, ACK, XFER, DONE} state_t;
   state_t state, next;
   logic [ADDR_W-1:0] ptr;
   logic last;
   // the sample taken at this edge is the final one
   assign last = !dev_req || word_count == CNT_W'(MAX_LEN - 1);
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         ptr        <= '0;
         word_count <= '0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         state  <= next;
         mem_we <= state == XFER;
         if (state == IDLE && enable && dev_req) begin
            ptr        <= base_addr;
            word_count <= '0;
         end
         if (state == XFER) begin
            mem_addr   <= ptr;
            mem_wdata  <= databus;
            ptr        <= ptr + ADDR_W'(1);
            word_count <= word_count + CNT_W'(1);
         end
      end
   end
   always_comb begin
      next        = state;
      bus_req     = state == BUSREQ || state == ACK || state == XFER;
      dev_ack     = state == ACK || state == XFER;
      dev_iowrite = !(state == ACK || state == XFER);
      busy        = state != IDLE;
      done        = state == DONE;
      case (state)
         IDLE:    next = (enable && dev_req) ? BUSREQ : IDLE;
         BUSREQ:  next = bus_grant ? ACK : (!dev_req ? DONE : BUSREQ);
         ACK:     next = XFER;
         XFER:    next = last ? DONE : XFER;
         default: next = IDLE;
      endcase
   end
endmodule

// File: tb/tb_dma_rx_channel.sv
// tb_dma_rx_channel: table-driven and randomized checks of dma_rx_channel
// against a device/CPU model and an expected write list.
module tb_dma_rx_channel;
   logic        clk = 1'b0;
   logic        reset, enable, dev_req, dev_ack, dev_iowrite, bus_req, bus_grant;
   logic        mem_we, busy, done;
   logic [7:0]  base_addr, mem_addr;
   logic [31:0] databus, mem_wdata;
   logic [5:0]  word_count;
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   dma_rx_channel dut (
      .clk(clk), .reset(reset), .enable(enable), .base_addr(base_addr),
      .dev_req(dev_req), .dev_ack(dev_ack), .dev_iowrite(dev_iowrite),
      .databus(databus), .bus_req(bus_req), .bus_grant(bus_grant),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .busy(busy), .done(done), .word_count(word_count)
   );

   typedef struct {
      logic [7:0] base;
      int         len;
      int         gdelay;
      bit         early;
      int         exp_wc;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // device + CPU model for one transfer; expected writes are the first
   // min(len, 32) words at consecutive addresses modulo 256
   task automatic run_xfer(input logic [7:0] base, input int len, input int gdelay,
                           input bit early, input bit rnd, input int exp_wc);
      logic [31:0] words[$];
      logic [7:0]  eaddr[$];
      logic [31:0] edata[$];
      int n, acks, breq, writes, dones, last_we, idx;
      bit granted, ack_early, gap;
      acks = 0; breq = 0; writes = 0; dones = 0; last_we = -1;
      granted = 0; ack_early = 0; gap = 0;
      for (int i = 0; i < len; i++) words.push_back(rnd ? $urandom : 32'(base) + 32'(i) + 1);
      n = early ? 0 : (len > 32 ? 32 : len);
      for (int i = 0; i < n; i++) begin
         eaddr.push_back(8'(int'(base) + i));
         edata.push_back(words[i]);
      end
      @(negedge clk);
      base_addr = base; enable = 1; dev_req = 1; bus_grant = 0; databus = words[0];
      for (int c = 0; c < 300 && dones == 0; c++) begin
         @(negedge clk);
         if (mem_we) begin
            if (writes < n) begin
               chk("wr_addr", 64'(mem_addr), 64'(eaddr[writes]));
               chk("wr_data", 64'(mem_wdata), 64'(edata[writes]));
            end
            if (last_we >= 0 && last_we != c - 1) gap = 1;
            last_we = c;
            writes++;
         end
         if (dev_ack && !granted) ack_early = 1;
         if (done) begin
            dones++;
            chk("wc_at_done", 64'(word_count), 64'(exp_wc));
         end
         idx = acks > 0 ? acks - 1 : 0;
         if (dev_ack) acks++;
         if (idx < len) databus = words[idx];
         if (bus_req) breq++;
         bus_grant = !early && bus_req && breq > gdelay;
         granted |= bus_grant;
         if (early && breq >= 2) dev_req = 0;
         if (acks > 0 && idx >= len - 1) dev_req = 0;
         if (done) dev_req = 0;
      end
      chk("done_seen", 64'(dones), 64'd1);
      repeat (3) begin
         @(negedge clk);
         if (mem_we) writes++;
         if (done) dones++;
      end
      chk("writes", 64'(writes), 64'(n));
      chk("dones", 64'(dones), 64'd1);
      chk("ack_before_grant", 64'(ack_early), 64'd0);
      chk("write_gap", 64'(gap), 64'd0);
      chk("busy_idle", 64'(busy), 64'd0);
      chk("ack_idle", 64'(dev_ack), 64'd0);
      chk("wc_hold", 64'(word_count), 64'(exp_wc));
   endtask

   initial begin
      vec_t vecs[$];
      int cnt, len;
      bit flag_busy, flag_req;
      vecs.push_back('{8'h10, 4, 2, 0, 4});
      vecs.push_back('{8'h20, 8, 10, 0, 8});
      vecs.push_back('{8'h28, 5, 20, 1, 0});
      vecs.push_back('{8'h30, 40, 1, 0, 32});
      vecs.push_back('{8'hFE, 4, 0, 0, 4});
      vecs.push_back('{8'h40, 1, 0, 0, 1});
      vecs.push_back('{8'h50, 32, 3, 0, 32});
      vecs.push_back('{8'h60, 33, 0, 0, 32});

      reset = 1; enable = 0; dev_req = 0; bus_grant = 0; base_addr = 0; databus = 0;
      repeat (3) @(negedge clk);
      reset = 0;
      @(negedge clk);
      chk("rst_ack", 64'(dev_ack), 64'd0);
      chk("rst_iowrite", 64'(dev_iowrite), 64'd1);
      chk("rst_bus_req", 64'(bus_req), 64'd0);
      chk("rst_we", 64'(mem_we), 64'd0);
      chk("rst_addr", 64'(mem_addr), 64'd0);
      chk("rst_wdata", 64'(mem_wdata), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_wc", 64'(word_count), 64'd0);

      foreach (vecs[i]) run_xfer(vecs[i].base, vecs[i].len, vecs[i].gdelay, vecs[i].early, 0, vecs[i].exp_wc);

      for (int r = 0; r < 15; r++) begin
         len = $urandom_range(1, 40);
         run_xfer(8'($urandom), len, $urandom_range(0, 4), 0, 1, len > 32 ? 32 : len);
      end

      // enable low gates the request
      enable = 0; dev_req = 1; flag_busy = 0; flag_req = 0;
      repeat (6) begin
         @(negedge clk);
         flag_busy |= busy;
         flag_req |= bus_req;
      end
      chk("gate_busy", 64'(flag_busy), 64'd0);
      chk("gate_bus_req", 64'(flag_req), 64'd0);
      dev_req = 0; enable = 1;
      @(negedge clk);

      // back-to-back: request held high across DONE
      base_addr = 8'h80; dev_req = 1; bus_grant = 1; databus = $urandom;
      cnt = 0;
      while (!done && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
      chk("b2b_first_done", 64'(done), 64'd1);
      chk("b2b_first_wc", 64'(word_count), 64'd32);
      @(negedge clk);
      chk("b2b_idle_gap", 64'(busy), 64'd0);
      @(negedge clk);
      chk("b2b_restart_busy", 64'(busy), 64'd1);
      chk("b2b_restart_req", 64'(bus_req), 64'd1);
      chk("b2b_wc_cleared", 64'(word_count), 64'd0);
      dev_req = 0; bus_grant = 0;
      @(negedge clk);
      chk("b2b_abort_done", 64'(done), 64'd1);
      chk("b2b_abort_wc", 64'(word_count), 64'd0);
      @(negedge clk);

      // reset during XFER after the 2nd word
      base_addr = 8'h20; dev_req = 1; bus_grant = 1;
      cnt = 0; len = 0;
      while (len < 2 && cnt < 50) begin
         @(negedge clk);
         databus = $urandom;
         if (mem_we) len++;
         cnt++;
      end
      chk("rst_xfer_words", 64'(len), 64'd2);
      reset = 1;
      @(negedge clk);
      chk("xr_we", 64'(mem_we), 64'd0);
      chk("xr_ack", 64'(dev_ack), 64'd0);
      chk("xr_iowrite", 64'(dev_iowrite), 64'd1);
      chk("xr_bus_req", 64'(bus_req), 64'd0);
      chk("xr_busy", 64'(busy), 64'd0);
      chk("xr_wc", 64'(word_count), 64'd0);
      chk("xr_addr", 64'(mem_addr), 64'd0);
      chk("xr_wdata", 64'(mem_wdata), 64'd0);
      reset = 0; dev_req = 0; bus_grant = 0;
      flag_busy = 0; flag_req = 0;
      repeat (5) begin
         @(negedge clk);
         flag_busy |= mem_we;
         flag_req |= done;
      end
      chk("xr_no_we", 64'(flag_busy), 64'd0);
      chk("xr_no_done", 64'(flag_req), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
